// File: rtl/gf_mult_share_ctrl_pkg.sv
// ============================================================================
// Module  : gf_mult_share_ctrl_pkg
// Brief   : Shared types and helpers for the time-shared GF/integer multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gf_mult_share_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int c_MIN_REQ = 2;
    localparam int c_MAX_REQ = 4;

    function automatic bit num_req_legal(input int n);
        return (n >= c_MIN_REQ) && (n <= c_MAX_REQ);
    endfunction

    // Index width never drops below one bit so a 2-requester build still has a pointer.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gf_rca_mult.sv
// ============================================================================
// Module  : gf_rca_mult
// Brief   : Combinational shift-and-add multiplier, carry-less or unsigned.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_rca_mult #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    input  logic                    i_gf,
    output logic [2*DATA_WIDTH-1:0] o_p
);

    logic [2*DATA_WIDTH-1:0] w_acc;
    logic [2*DATA_WIDTH-1:0] w_pp;

    // Same partial-product array for both modes; only the accumulate operator differs.
    always_comb begin
        w_acc = '0;
        w_pp  = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_pp  = i_b[i] ? ({{DATA_WIDTH{1'b0}}, i_a} << i) : '0;
            w_acc = i_gf ? (w_acc ^ w_pp) : (w_acc + w_pp);
        end
        o_p = w_acc;
    end

endmodule

`default_nettype wire

// File: rtl/gf_rr_arbiter.sv
// ============================================================================
// Module  : gf_rr_arbiter
// Brief   : Combinational round-robin picker: first request at or after pointer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_rr_arbiter
    import gf_mult_share_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_any && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
                o_grant[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
                o_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
                o_any = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gf_mult_share_ctrl.sv
// ============================================================================
// Module  : gf_mult_share_ctrl
// Brief   : Round-robin time-sharing of one multiplier among NUM_REQ clients.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_mult_share_ctrl
    import gf_mult_share_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    output logic [NUM_REQ-1:0]              o_req_ready,
    input  logic [NUM_REQ-1:0]              i_req_gf,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_b,
    output logic [NUM_REQ-1:0]              o_rsp_valid,
    input  logic [NUM_REQ-1:0]              i_rsp_ready,
    output logic [2*DATA_WIDTH-1:0]         o_rsp_data,
    output logic                            o_busy
);

    localparam int IDX_W = idx_width(NUM_REQ);

    if (!num_req_legal(NUM_REQ)) begin : g_bad_num_req
        $error("gf_mult_share_ctrl: NUM_REQ must be in 2..4");
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        r_owner;
    logic [DATA_WIDTH-1:0]   r_op_a;
    logic [DATA_WIDTH-1:0]   r_op_b;
    logic                    r_op_gf;
    logic [2*DATA_WIDTH-1:0] r_rsp_data;

    logic [NUM_REQ-1:0]      w_grant;
    logic [IDX_W-1:0]        w_grant_idx;
    logic                    w_any;
    logic [NUM_REQ-1:0]      w_owner_oh;
    logic [IDX_W-1:0]        w_ptr_nxt;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [NUM_REQ-1:0]      w_req_ready;
    logic [NUM_REQ-1:0]      w_rsp_valid;
    logic                    w_accept;
    logic                    w_handshake;

    gf_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_any)
    );

    gf_rca_mult #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .i_a  (r_op_a),
        .i_b  (r_op_b),
        .i_gf (r_op_gf),
        .o_p  (w_prod)
    );

    assign w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_ptr_nxt  = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_rsp_valid = '0;
        w_accept    = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_req_ready = w_grant;
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_valid = w_owner_oh;
                if (i_rsp_ready[r_owner]) begin
                    w_handshake = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_owner    <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_gf    <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant_idx;
                r_op_a  <= i_req_a[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
                r_op_b  <= i_req_b[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
                r_op_gf <= i_req_gf[w_grant_idx];
            end
            if (r_state == ST_EXEC) begin
                r_rsp_data <= w_prod;
            end
            if (w_handshake) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // The grant is combinational from live requests, so mask it while reset is held.
    assign o_req_ready = rst_n ? w_req_ready : '0;
    assign o_rsp_valid = w_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_gf_mult_share_ctrl.sv
// ============================================================================
// Module  : tb_gf_mult_share_ctrl
// Brief   : Directed self-checking bench for the shared multiplier controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf_mult_share_ctrl;

    localparam int DW = 32;
    localparam int NR = 2;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_gf;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR-1:0]   rsp_valid;
    logic [NR-1:0]   rsp_ready;
    logic [2*DW-1:0] rsp_data;
    logic            busy;

    int n_vec;
    int n_err;

    gf_mult_share_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_gf    (req_gf),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op from an idle controller and consume its response; the caller checks.
    task automatic do_op(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic gf, output logic [2*DW-1:0] data,
                         output logic [NR-1:0] vld, output logic [NR-1:0] rdy, output int lat);
        @(posedge clk); #1;
        req_valid[idx]         = 1'b1;
        req_a[idx*DW +: DW]    = a;
        req_b[idx*DW +: DW]    = b;
        req_gf[idx]            = gf;
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        lat  = 0;
        vld  = '0;
        data = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                lat  = k;
                vld  = rsp_valid;
                data = rsp_data;
                break;
            end
        end
        rsp_ready[idx] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_gf    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        n_vec++; if (rsp_data !== 64'h0) begin n_err++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single(input string nm, input int idx, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic gf, input logic [2*DW-1:0] exp);
        logic [2*DW-1:0] d;
        logic [NR-1:0]   v, r;
        int              lat;
        do_op(idx, a, b, gf, d, v, r, lat);
        n_vec++; if (r !== NR'(1 << idx)) begin n_err++; $display("FAIL %s_req_ready got=%b exp=%b", nm, r, NR'(1 << idx)); end
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL %s_latency got=%0d exp=2", nm, lat); end
        n_vec++; if (v !== NR'(1 << idx)) begin n_err++; $display("FAIL %s_rsp_valid got=%b exp=%b", nm, v, NR'(1 << idx)); end
        n_vec++; if (d !== exp) begin n_err++; $display("FAIL %s_rsp_data got=%h exp=%h", nm, d, exp); end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] g [4];
        int            t [4];
        int            gc;
        int            waitc;
        @(posedge clk); #1;
        req_a = {32'd7, 32'd2};
        req_b = {32'd7, 32'd5};
        req_gf = 2'b10;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        gc = 0;
        for (int c = 0; c < 40 && gc < 4; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g[gc] = req_ready;
                t[gc] = c;
                gc++;
            end
            if (rsp_valid == 2'b01) begin
                n_vec++; if (rsp_data !== 64'd10) begin n_err++; $display("FAIL b2b_data0 got=%h exp=%h", rsp_data, 64'd10); end
            end else if (rsp_valid == 2'b10) begin
                n_vec++; if (rsp_data !== 64'd21) begin n_err++; $display("FAIL b2b_data1 got=%h exp=%h", rsp_data, 64'd21); end
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        waitc = 0;
        while (busy && waitc < 6) begin
            @(negedge clk);
            if (rsp_valid == 2'b10) begin
                n_vec++; if (rsp_data !== 64'd21) begin n_err++; $display("FAIL b2b_data_last got=%h exp=%h", rsp_data, 64'd21); end
            end
            waitc++;
        end
        rsp_ready = 2'b00;
        n_vec++; if (gc != 4) begin n_err++; $display("FAIL b2b_grant_count got=%0d exp=4", gc); end
        if (gc == 4) begin
            n_vec++; if (g[0] !== 2'b01 || g[1] !== 2'b10 || g[2] !== 2'b01 || g[3] !== 2'b10) begin
                n_err++; $display("FAIL b2b_grant_order got=%b,%b,%b,%b exp=01,10,01,10", g[0], g[1], g[2], g[3]);
            end
            n_vec++; if (t[1] - t[0] != 3 || t[2] - t[1] != 3 || t[3] - t[2] != 3) begin
                n_err++; $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=3,3,3", t[1]-t[0], t[2]-t[1], t[3]-t[2]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit got;
        bit stable;
        bit rdy_zero;
        @(negedge clk);
        @(posedge clk); #1;
        req_a = {32'd5, 32'd11};
        req_b = {32'd3, 32'd13};
        req_gf = 2'b10;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) got = 1'b1;
        end
        n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL bp_first_owner got=%b exp=01", rsp_valid); end
        n_vec++; if (rsp_data !== 64'd143) begin n_err++; $display("FAIL bp_first_data got=%h exp=%h", rsp_data, 64'd143); end
        stable   = 1'b1;
        rdy_zero = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            rsp_ready = 2'b10;
            @(negedge clk);
            if (rsp_valid !== 2'b01 || rsp_data !== 64'd143 || busy !== 1'b1) stable = 1'b0;
            if (req_ready !== 2'b00) rdy_zero = 1'b0;
        end
        n_vec++; if (!stable) begin n_err++; $display("FAIL bp_hold got=%b/%h exp=01/%h", rsp_valid, rsp_data, 64'd143); end
        n_vec++; if (!rdy_zero) begin n_err++; $display("FAIL bp_req_ready got=nonzero exp=00"); end
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_next_grant got=%b exp=10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) got = 1'b1;
        end
        n_vec++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL bp_second_owner got=%b exp=10", rsp_valid); end
        n_vec++; if (rsp_data !== 64'd15) begin n_err++; $display("FAIL bp_second_data got=%h exp=%h", rsp_data, 64'd15); end
        rsp_ready = 2'b10;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset_mid();
        bit stale;
        bit got;
        test_single("pre_abort", 0, 32'd1, 32'd1, 1'b0, 64'd1);
        @(posedge clk); #1;
        req_a[DW +: DW] = 32'd6;
        req_b[DW +: DW] = 32'd7;
        req_gf[1]       = 1'b0;
        req_valid       = 2'b10;
        @(negedge clk);
        n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL abort_grant got=%b exp=10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b11;
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL abort_req_ready got=%b exp=00", req_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
        n_vec++; if (rsp_data !== 64'h0) begin n_err++; $display("FAIL abort_rsp_data got=%h exp=0", rsp_data); end
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00 || busy !== 1'b0) stale = 1'b0 | 1'b1;
        end
        n_vec++; if (stale) begin n_err++; $display("FAIL abort_stale_rsp got=active exp=idle"); end
        @(posedge clk); #1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        @(negedge clk);
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL abort_ptr_reset got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) got = 1'b1;
        end
        n_vec++; if (rsp_valid !== 2'b01 || rsp_data !== 64'd1) begin
            n_err++; $display("FAIL abort_recover got=%b/%h exp=01/%h", rsp_valid, rsp_data, 64'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b00;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single("gf_3x3",   0, 32'd3, 32'd3, 1'b1, 64'd5);
        test_single("int_3x3",  1, 32'd3, 32'd3, 1'b0, 64'd9);
        test_single("int_max",  0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        test_single("gf_max",   1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h5555_5555_5555_5555);
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
